// File: rtl/div_20b_seq.sv
// Restoring divider: normalises a weighted pixel sum by its weight sum, one quotient bit per clock.
// Returns quotient, remainder and a pixel saturated to 255; a zero divisor yields an all-ones quotient.
module div_20b_seq #(
  parameter int WIDTH = 20,
  parameter int DIV_W = 12,
  parameter int ROUND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic [7:0]       pix_out,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 2);

  state_t           state_q;
  logic [WIDTH:0]   d_q;
  logic [WIDTH-1:0] q_q;
  logic [DIV_W-1:0] dvs_q;
  logic [DIV_W-1:0] r_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quo_q;
  logic [DIV_W-1:0] rem_q;
  logic [7:0]       pix_q;
  logic             dbz_q;

  logic [WIDTH:0]   d_adj;
  logic [DIV_W:0]   r_sh;
  logic             ge;
  logic [DIV_W-1:0] r_sub;
  logic [DIV_W-1:0] r_d;
  logic [WIDTH:0]   q_d;
  logic [7:0]       pix_d;

  // Rounding bias is added at WIDTH+1 bits so the largest sum cannot wrap.
  assign d_adj = {1'b0, dividend} + ((ROUND != 0) ? (WIDTH+1)'(divisor >> 1) : '0);

  assign r_sh  = {r_q, d_q[WIDTH]};
  assign ge    = (r_sh >= {1'b0, dvs_q});
  // The true difference is below 2^DIV_W whenever it is taken, so the wrap-around subtract is exact.
  assign r_sub = r_sh[DIV_W-1:0] - dvs_q;
  assign r_d   = ge ? r_sub : r_sh[DIV_W-1:0];
  assign q_d   = {q_q, ge};
  assign pix_d = (|q_d[WIDTH:8]) ? 8'hFF : q_d[7:0];

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign pix_out     = pix_q;
  assign div_by_zero = dbz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      pix_q       <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvs_q <= divisor;
            d_q   <= d_adj;
            r_q   <= '0;
            q_q   <= '0;
            cnt_q <= CW'(WIDTH + 1);
            if (divisor == '0) begin
              quo_q       <= '1;
              rem_q       <= '0;
              pix_q       <= 8'hFF;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d[WIDTH-1:0];
          d_q   <= {d_q[WIDTH-1:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quo_q       <= q_d[WIDTH-1:0];
            rem_q       <= r_d;
            pix_q       <= pix_d;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_20b_seq.sv
// Directed bench for div_20b_seq: a ROUND=1 and a ROUND=0 instance fed the same transactions.
module tb_div_20b_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] dividend = '0;
  logic [11:0] divisor = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, dbz0;
  logic [19:0] quo0;
  logic [11:0] rem0;
  logic [7:0]  pix0;
  logic        in_ready1, out_valid1, dbz1;
  logic [19:0] quo1;
  logic [11:0] rem1;
  logic [7:0]  pix1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_20b_seq #(.WIDTH(20), .DIV_W(12), .ROUND(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid0), .out_ready(out_ready),
    .quotient(quo0), .remainder(rem0), .pix_out(pix0), .div_by_zero(dbz0)
  );

  div_20b_seq #(.WIDTH(20), .DIV_W(12), .ROUND(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid1), .out_ready(out_ready),
    .quotient(quo1), .remainder(rem1), .pix_out(pix1), .div_by_zero(dbz1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one transaction, then scramble the inputs to prove they are sampled only at acceptance.
  task automatic issue(input string tag, input logic [19:0] a, input logic [11:0] b);
    @(negedge clk);
    chk({tag, "/in_ready"}, 32'(in_ready0), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 20'h5A5A5;
    divisor  = 12'h777;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int cyc = 0;
    while (!out_valid0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "/in_ready_busy"}, 32'(in_ready0), 32'd0);
  endtask

  task automatic chk_res(input string tag, input logic [19:0] q, input logic [11:0] r,
                         input logic [7:0] p, input logic z);
    chk({tag, "/quotient"}, 32'(quo0), 32'(q));
    chk({tag, "/remainder"}, 32'(rem0), 32'(r));
    chk({tag, "/pix_out"}, 32'(pix0), 32'(p));
    chk({tag, "/div_by_zero"}, 32'(dbz0), 32'(z));
  endtask

  task automatic chk_res1(input string tag, input logic [19:0] q, input logic [11:0] r);
    chk({tag, "/r0_valid"}, 32'(out_valid1), 32'd1);
    chk({tag, "/r0_quotient"}, 32'(quo1), 32'(q));
    chk({tag, "/r0_remainder"}, 32'(rem1), 32'(r));
  endtask

  task automatic handshake(input string tag, input logic [19:0] q);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "/hs_out_valid"}, 32'(out_valid0), 32'd0);
    chk({tag, "/hs_in_ready"}, 32'(in_ready0), 32'd1);
    chk({tag, "/hs_q_kept"}, 32'(quo0), 32'(q));
  endtask

  initial begin
    #12;
    chk("rst/out_valid", 32'(out_valid0), 32'd0);
    chk("rst/quotient", 32'(quo0), 32'd0);
    rst_n = 1'b1;
    #6;
    chk("rst/in_ready", 32'(in_ready0), 32'd1);
    chk_res("rst", 20'd0, 12'd0, 8'd0, 1'b0);

    // 2295+4 = 2299 = 255*9 + 4; truncating: 2295 = 255*9
    issue("a", 20'd2295, 12'd9);
    wait_out("a", 21);
    chk_res("a", 20'd255, 12'd4, 8'd255, 1'b0);
    chk_res1("a", 20'd255, 12'd0);
    handshake("a", 20'd255);

    // (10+2)/4 = 3 r0; 10/4 = 2 r2
    issue("b", 20'd10, 12'd4);
    wait_out("b", 21);
    chk_res("b", 20'd3, 12'd0, 8'd3, 1'b0);
    chk_res1("b", 20'd2, 12'd2);
    handshake("b", 20'd3);

    issue("c", 20'hFFFFF, 12'd1);
    wait_out("c", 21);
    chk_res("c", 20'hFFFFF, 12'd0, 8'd255, 1'b0);
    chk_res1("c", 20'hFFFFF, 12'd0);
    handshake("c", 20'hFFFFF);

    issue("z", 20'd500, 12'd0);
    wait_out("z", 0);
    chk_res("z", 20'hFFFFF, 12'd0, 8'd255, 1'b1);
    chk("z/r0_dbz", 32'(dbz1), 32'd1);
    handshake("z", 20'hFFFFF);

    // (1000+2)/4 = 250 r2; 1000/4 = 250 r0
    issue("d", 20'd1000, 12'd4);
    wait_out("d", 21);
    chk_res("d", 20'd250, 12'd2, 8'd250, 1'b0);
    chk_res1("d", 20'd250, 12'd0);
    handshake("d", 20'd250);

    // (7+1)/2 = 4 r0, held under backpressure while a new request is offered
    issue("bp", 20'd7, 12'd2);
    wait_out("bp", 21);
    @(negedge clk);
    dividend = 20'd999;
    divisor  = 12'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp/hold_valid", 32'(out_valid0), 32'd1);
      chk("bp/hold_in_ready", 32'(in_ready0), 32'd0);
      chk("bp/hold_q", 32'(quo0), 32'd4);
    end
    in_valid = 1'b0;
    chk_res("bp", 20'd4, 12'd0, 8'd4, 1'b0);
    handshake("bp", 20'd4);
    @(posedge clk);
    #1;
    chk("bp/no_ghost", 32'(out_valid0), 32'd0);

    // Abort 100/3 during iteration 7 with an asynchronous reset
    issue("rs", 20'd100, 12'd3);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs/out_valid", 32'(out_valid0), 32'd0);
    chk_res("rs", 20'd0, 12'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rs/in_ready", 32'(in_ready0), 32'd1);
    // (100+1)/3 = 33 r2
    issue("rs2", 20'd100, 12'd3);
    wait_out("rs2", 21);
    chk_res("rs2", 20'd33, 12'd2, 8'd33, 1'b0);
    handshake("rs2", 20'd33);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/div_20b_seq.md
Name: div_20b_seq

Overview:
Multi-cycle restoring divider that normalises a 20-bit weighted pixel accumulation back to pixel range. It divides the accumulated sum by the summed interpolation weight. It sits downstream of the 20-bit accumulator chain in the upscaler datapath. It takes one 20-bit dividend and one weight-sum divisor per transaction over valid/ready handshakes, and returns the full quotient, the remainder and an 8-bit saturated pixel.

Parameters:
WIDTH, 20, dividend and quotient width
DIV_W, 12, divisor and remainder width
ROUND, 1, 1 = round-half-up (adds divisor>>1 to dividend before dividing); 0 = truncate

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  dividend/divisor valid
in_ready  output  1  block can accept a transaction
dividend  input  WIDTH  accumulated sum (unsigned)
divisor  input  DIV_W  weight sum (unsigned)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
quotient  output  WIDTH  unsigned quotient
remainder  output  DIV_W  remainder of the (rounding-adjusted) dividend
pix_out  output  8  quotient saturated to 255
div_by_zero  output  1  divisor was zero for this result

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1 after release, out_valid=0, quotient=0, remainder=0, pix_out=0, div_by_zero=0. Reset mid-CALC or mid-DONE aborts the operation and discards the result.
- States are IDLE, CALC and DONE. in_ready = (state==IDLE), derived combinationally from the state register only.
- IDLE: on in_valid & in_ready at edge E0:
  - Latch divisor.
  - Latch adjusted dividend D = dividend + (ROUND ? divisor>>1 : 0), computed at WIDTH+1 bits (no overflow).
  - Clear the partial remainder and load the iteration counter with WIDTH+1.
  - Go to CALC. If divisor==0, go straight to DONE instead (see below).
- CALC: one quotient bit per clock, MSB first, restoring algorithm:
  - r' = {r, next D bit}, at DIV_W+1 bits.
  - If r' >= divisor: r = r' - divisor and q bit = 1; else r = r' and q bit = 0.
  - After WIDTH+1 iterations (edges E1..E21 at default WIDTH), register the outputs and go to DONE, with out_valid=1 visible from the cycle after E21.
  - Latency from the acceptance edge to out_valid is therefore WIDTH+1 clocks.
- Width rules:
  - The internal quotient is WIDTH+1 bits. For divisor>=1 the adjusted quotient is always < 2^WIDTH, so quotient = low WIDTH bits, no loss.
  - pix_out = (quotient > 255) ? 255 : quotient[7:0].
- Divide by zero: accepted normally, then DONE one clock after acceptance with:
  - quotient = all ones
  - remainder = 0
  - pix_out = 255
  - div_by_zero = 1
- DONE: outputs are held stable while out_valid & !out_ready. On out_valid & out_ready: out_valid=0 at the next edge, go to IDLE.
  - in_ready stays low throughout DONE, even when out_ready is high.
  - Minimum spacing between accepts is therefore WIDTH+3 clocks.
  - quotient, remainder, pix_out and div_by_zero keep their last values after the handshake until the next result is loaded.
- Inputs are ignored while in_ready=0. dividend/divisor are sampled only at the acceptance edge, so later changes have no effect.
- div_by_zero is cleared on the next normal result.

Test Plan:
- ROUND=1, dividend=2295, divisor=9 -> after 21 clocks: quotient=255, remainder=4, pix_out=255, div_by_zero=0.
- ROUND=1 vs ROUND=0, dividend=10, divisor=4 -> ROUND=1: quotient=3, remainder=0. ROUND=0: quotient=2, remainder=2.
- dividend=20'hFFFFF, divisor=1 (ROUND=1) -> quotient=1048575, remainder=0, pix_out=255 (saturated).
- dividend=500, divisor=0 -> out_valid one clock after accept: quotient=20'hFFFFF, remainder=0, pix_out=255, div_by_zero=1. A following 1000/4 (ROUND=1) -> quotient=250, remainder=2, div_by_zero=0.
- Backpressure: hold out_ready=0 for 10 clocks after out_valid -> outputs unchanged, in_ready=0, and a new in_valid is ignored. Raise out_ready -> one handshake, then in_ready=1 the next cycle.
- Assert rst_n=0 asynchronously at iteration 7 of 100/3 -> out_valid=0 and outputs zero immediately. After release, in_ready=1 and a new 100/3 (ROUND=1) yields quotient=33, remainder=2.
